halo_exchange_scheduler: RTL and testbench
==========================================

// Module: halo_exchange_scheduler
// PURPOSE
//  Sequences the PPU halo exchange after each channel group. Walks the tile-border regions needed by all
//  8 neighbours and reads each element from the output buffer banks. Streams nonzero values onto the matching
//  neighbor_output port under neighbor CTS flow control. Then handshakes exchange_done with all neighbours and
//  pulses cycle_done. Sits in ppu beside neighbor_input_processor and drives the ppu neighbour outputs.
// PARAMETERS
//  TILE_SIZE   256  tile rows = tile columns; RW = $clog2(TILE_SIZE)
//  BANK_COUNT  32   output buffer banks; element (r,c) lives in bank c % BANK_COUNT
// PORTS
//  clk                           in   1          clock
//  reset                         in   1          synchronous, active-high reset
//  kernel_size                   in   3          halo h = kernel_size>>1; sampled at start
//  channel_group_done            in   1          start pulse
//  local_inputs_pending          in   1          neighbor_input_processor still holds leftovers
//  buffer_bank_read              out  $clog2(BANK_COUNT)  bank to read
//  buffer_read_row               out  RW         row to read
//  buffer_read_column            out  RW         column to read
//  buffer_data_read              in   8          read data, valid 1 cycle after address
//  neighbor_cts[8]               in   1 each     neighbour d accepts writes
//  neighbor_exchange_done[8]     in   1 each     neighbour d has finished sending
//  neighbor_output_value[8]      out  8 each     value to neighbour d
//  neighbor_output_row[8]        out  RW each    local row of value
//  neighbor_output_column[8]     out  RW each    local column of value
//  neighbor_output_write_enable[8] out 1 each    write strobe to neighbour d
//  exchange_done                 out  1          local send phase complete (level)
//  busy                          out  1          state != IDLE
//  cycle_done                    out  1          one-cycle pulse: exchange fully complete
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including all write_enables, exchange_done, busy and cycle_done.
//  Directions d: 0=N 1=NE 2=E 3=SE 4=S 5=SW 6=W 7=NW. Send regions use local coordinates (L=TILE_SIZE):
//   N  rows[0,h)   cols[0,L)  | NE rows[0,h)   cols[L-h,L) | E rows[0,L)   cols[L-h,L) | SE rows[L-h,L) cols[L-h,L)
//   S  rows[L-h,L) cols[0,L)  | SW rows[L-h,L) cols[0,h)   | W rows[0,L)   cols[0,h)   | NW rows[0,h)   cols[0,h)
//  Scan order: d ascending, then row-major within the region.
//  FSM: IDLE -> SCAN -> DRAIN -> WAIT_NB -> DONE -> IDLE.
//   IDLE: on channel_group_done, latch h and set d=0. Go to SCAN if h!=0; go to WAIT_NB if h==0.
//   SCAN: issue one read per cycle for direction d, only in cycles where neighbor_cts[d]=1.
//         If CTS is low, hold the address and issue no read.
//         The final read of direction d advances d with zero bubbles.
//         The final read of d=7 moves to DRAIN.
//   DRAIN: 1 cycle; the last read's data is written. Then go to WAIT_NB.
//   WAIT_NB: exchange_done=1. Stay until all neighbor_exchange_done are 1 and local_inputs_pending=0.
//   DONE: cycle_done=1 for one cycle; exchange_done falls. Return to IDLE.
//  Write pipeline:
//   - A read issued in cycle t for direction d gives, in cycle t+1, neighbor_output_* on port d only.
//   - Value = buffer_data_read; row/column = the issued coordinates.
//   - write_enable[d] = (data != 0); zero values are dropped (sparse).
//  Flow control: a neighbour must absorb one write in the cycle after it drops CTS. Data is never lost or duplicated.
//  Only one write_enable is asserted in any cycle. Non-asserted ports drive value, row and column as 0.
//  Row/column counters are RW+1 bits wide for compares. Range [L-h,L) is computed in RW+1 bits; there is no wrap.
//  h > L/2 is illegal and unchecked. h is frozen while busy.
//  channel_group_done while busy is ignored.
//  Reset mid-operation: return to IDLE next cycle and drop every output to its reset value, including the
//  in-flight write.
// STRUCTURE
//  Package ppu_pkg: direction_t enum (N..NW), ppu_state_t enum, NUM_NEIGHBORS=8.
//  Sub-module halo_region_iter:
//   - Inputs: d, h, advance.
//   - Outputs: row, col, last_in_region.
//   - Computes region bounds and performs the row-major step.
//  The top level holds the FSM, the read pipeline register (valid, d, row, col) and the output fan-out.
// TESTING (TILE_SIZE=8, BANK_COUNT=4, all cts=1 unless noted)
//  1. kernel_size=3, all data nonzero, start at cycle 0.
//     -> 36 reads in cycles 1..36; 36 writes in cycles 2..37 (per d: 8,1,8,1,8,1,8,1).
//     -> exchange_done=1 from cycle 38.
//  2. Case 1 with neighbor_exchange_done raised at cycle 50 -> cycle_done pulses exactly once at cycle 51.
//  3. kernel_size=1 -> no reads, exchange_done next cycle; then cycle_done once neighbours are done.
//  4. Drop cts[2] for 5 cycles mid-E.
//     -> exactly one further E write, then none until CTS returns; no loss or duplicate; total still 36.
//  5. Buffer returns 0 at (0,3) -> N write for (0,3) suppressed; total writes 35.
//  6. reset at cycle 10 of case 1 -> next cycle all outputs 0 and IDLE; a new start runs case 1 cleanly.
//  7. kernel_size=5 -> 2*8+4+2*8+4+... = 80 reads; last write of NW at row 1, col 1.

Source files
------------

// File: rtl/halo_exchange_scheduler_pkg.sv
// ppu_pkg: shared types for the PPU halo exchange scheduler.
//  - NUM_NEIGHBORS : number of neighbour ports (8 compass directions)
//  - direction_t   : neighbour direction, also the scan order (N first, NW last)
//  - ppu_state_t   : scheduler FSM states
//  - span_t        : how a direction's region spans one axis of the tile
//  - row_span/col_span : maps a direction onto the row and column spans of its send region
package ppu_pkg;

    localparam int NUM_NEIGHBORS = 8;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } direction_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_WAIT_NB = 3'd3,
        ST_DONE    = 3'd4
    } ppu_state_t;

    // LOW = first h lines, HIGH = last h lines, FULL = the whole axis.
    typedef enum logic [1:0] {
        SPAN_LOW  = 2'd0,
        SPAN_HIGH = 2'd1,
        SPAN_FULL = 2'd2
    } span_t;

    function automatic span_t row_span(direction_t d);
        case (d)
            DIR_N, DIR_NE, DIR_NW: return SPAN_LOW;
            DIR_SE, DIR_S, DIR_SW: return SPAN_HIGH;
            default:               return SPAN_FULL;
        endcase
    endfunction

    function automatic span_t col_span(direction_t d);
        case (d)
            DIR_NE, DIR_E, DIR_SE: return SPAN_HIGH;
            DIR_SW, DIR_W, DIR_NW: return SPAN_LOW;
            default:               return SPAN_FULL;
        endcase
    endfunction

endpackage

// File: rtl/halo_exchange_scheduler_if.sv
// halo_exchange_scheduler_if: output-buffer read bus plus the eight neighbour
// write/flow-control channels of the halo exchange scheduler.
//  master (scheduler): drives bank/row/column read address and all neighbour
//                      outputs; receives read data, CTS and neighbour done flags.
//  slave  (buffer banks + neighbours): the mirror image.
// Read data is expected one cycle after the address is presented.
interface halo_exchange_scheduler_if #(
    parameter int TILE_SIZE  = 256,
    parameter int BANK_COUNT = 32
);
    localparam int RW = $clog2(TILE_SIZE);
    localparam int BW = $clog2(BANK_COUNT);
    localparam int NN = ppu_pkg::NUM_NEIGHBORS;

    logic [BW-1:0]         buffer_bank_read;
    logic [RW-1:0]         buffer_read_row;
    logic [RW-1:0]         buffer_read_column;
    logic [7:0]            buffer_data_read;

    logic [NN-1:0]         neighbor_cts;
    logic [NN-1:0]         neighbor_exchange_done;
    logic [NN-1:0][7:0]    neighbor_output_value;
    logic [NN-1:0][RW-1:0] neighbor_output_row;
    logic [NN-1:0][RW-1:0] neighbor_output_column;
    logic [NN-1:0]         neighbor_output_write_enable;

    modport master (
        output buffer_bank_read, buffer_read_row, buffer_read_column,
        input  buffer_data_read,
        input  neighbor_cts, neighbor_exchange_done,
        output neighbor_output_value, neighbor_output_row,
        output neighbor_output_column, neighbor_output_write_enable
    );

    modport slave (
        input  buffer_bank_read, buffer_read_row, buffer_read_column,
        output buffer_data_read,
        output neighbor_cts, neighbor_exchange_done,
        input  neighbor_output_value, neighbor_output_row,
        input  neighbor_output_column, neighbor_output_write_enable
    );

endinterface

// File: rtl/halo_exchange_scheduler_region_iter.sv
// halo_region_iter: row-major walker over the send region of one direction.
//  clk, reset     : clock, synchronous active-high reset
//  load           : jump to the first element of the region of d (with halo h)
//  advance        : step to the next element; stepping past the last element of
//                   d jumps straight to the first element of d+1 (no bubble)
//  d, h           : current direction and halo width
//  row, col       : current element coordinates
//  last_in_region : current element is the last of direction d
// Counters are one bit wider than a coordinate so that L and L-h are
// representable during compares.
module halo_region_iter
    import ppu_pkg::*;
#(
    parameter int TILE_SIZE = 256,
    localparam int RW = $clog2(TILE_SIZE),
    localparam int CW = RW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  direction_t    d,
    input  logic [CW-1:0] h,
    output logic [RW-1:0] row,
    output logic [RW-1:0] col,
    output logic          last_in_region
);

    localparam logic [CW-1:0] L_W = CW'(TILE_SIZE);

    function automatic logic [CW-1:0] span_lo(span_t s, logic [CW-1:0] hv);
        return (s == SPAN_HIGH) ? (L_W - hv) : '0;
    endfunction

    function automatic logic [CW-1:0] span_hi(span_t s, logic [CW-1:0] hv);
        return (s == SPAN_LOW) ? hv : L_W;
    endfunction

    logic [CW-1:0] row_reg, col_reg;
    logic [CW-1:0] row_lo, col_lo, row_last, col_last;
    logic [CW-1:0] succ_row_lo, succ_col_lo;
    direction_t    d_succ;

    always_comb begin
        d_succ      = direction_t'(d + 3'd1);
        row_lo      = span_lo(row_span(d), h);
        col_lo      = span_lo(col_span(d), h);
        row_last    = span_hi(row_span(d), h) - CW'(1);
        col_last    = span_hi(col_span(d), h) - CW'(1);
        succ_row_lo = span_lo(row_span(d_succ), h);
        succ_col_lo = span_lo(col_span(d_succ), h);
    end

    assign last_in_region = (row_reg == row_last) && (col_reg == col_last);
    assign row            = row_reg[RW-1:0];
    assign col            = col_reg[RW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (load) begin
            row_reg <= row_lo;
            col_reg <= col_lo;
        end else if (advance) begin
            if (last_in_region) begin
                row_reg <= succ_row_lo;
                col_reg <= succ_col_lo;
            end else if (col_reg == col_last) begin
                row_reg <= row_reg + CW'(1);
                col_reg <= col_lo;
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/halo_exchange_scheduler.sv
// halo_exchange_scheduler: after each channel group, reads the tile border
// regions for all 8 neighbours from the output buffer and streams the nonzero
// values to the matching neighbour port, then waits for every neighbour to
// finish before pulsing cycle_done.
//  clk, reset            : clock, synchronous active-high reset
//  kernel_size           : halo h = kernel_size>>1, sampled at start
//  channel_group_done    : start pulse (ignored while busy)
//  local_inputs_pending  : local input processor still holds leftovers
//  bus (master)          : buffer read address/data and neighbour channels
//  exchange_done         : local send phase finished (level, WAIT_NB)
//  busy                  : scheduler not idle
//  cycle_done            : one-cycle pulse when the whole exchange is complete
module halo_exchange_scheduler
    import ppu_pkg::*;
#(
    parameter int TILE_SIZE  = 256,
    parameter int BANK_COUNT = 32,
    localparam int RW = $clog2(TILE_SIZE),
    localparam int CW = RW + 1,
    localparam int BW = $clog2(BANK_COUNT)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] kernel_size,
    input  logic       channel_group_done,
    input  logic       local_inputs_pending,
    halo_exchange_scheduler_if.master bus,
    output logic       exchange_done,
    output logic       busy,
    output logic       cycle_done
);

    ppu_state_t    state_reg, state_next;
    direction_t    d_reg;
    logic [CW-1:0] h_reg, h_start;

    logic          start, scanning, read_issue, last_in_region;
    direction_t    iter_d;
    logic [CW-1:0] iter_h;
    logic [RW-1:0] iter_row, iter_col;

    // Read pipeline: the address issued this cycle becomes a write next cycle.
    logic          pipe_valid_reg;
    direction_t    pipe_d_reg;
    logic [RW-1:0] pipe_row_reg, pipe_col_reg;

    assign h_start  = CW'(kernel_size >> 1);
    assign start    = (state_reg == ST_IDLE) && channel_group_done;
    assign scanning = (state_reg == ST_SCAN);

    // The iterator loads region N with the freshly sampled halo on start.
    assign iter_d = (state_reg == ST_IDLE) ? DIR_N   : d_reg;
    assign iter_h = (state_reg == ST_IDLE) ? h_start : h_reg;

    halo_region_iter #(
        .TILE_SIZE (TILE_SIZE)
    ) u_region_iter (
        .clk            (clk),
        .reset          (reset),
        .load           (start),
        .advance        (read_issue),
        .d              (iter_d),
        .h              (iter_h),
        .row            (iter_row),
        .col            (iter_col),
        .last_in_region (last_in_region)
    );

    always_comb begin
        state_next = state_reg;
        read_issue = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (channel_group_done) begin
                    state_next = (h_start == '0) ? ST_WAIT_NB : ST_SCAN;
                end
            end
            ST_SCAN: begin
                // With CTS low the address is held and no read is issued.
                if (bus.neighbor_cts[d_reg]) begin
                    read_issue = 1'b1;
                    if (last_in_region && (d_reg == DIR_NW)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN:   state_next = ST_WAIT_NB;
            ST_WAIT_NB: begin
                if ((&bus.neighbor_exchange_done) && !local_inputs_pending) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            d_reg          <= DIR_N;
            h_reg          <= '0;
            pipe_valid_reg <= 1'b0;
            pipe_d_reg     <= DIR_N;
            pipe_row_reg   <= '0;
            pipe_col_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                d_reg <= DIR_N;
                h_reg <= h_start;
            end else if (read_issue && last_in_region && (d_reg != DIR_NW)) begin
                d_reg <= direction_t'(d_reg + 3'd1);
            end
            pipe_valid_reg <= read_issue;
            if (read_issue) begin
                pipe_d_reg   <= d_reg;
                pipe_row_reg <= iter_row;
                pipe_col_reg <= iter_col;
            end
        end
    end

    assign exchange_done = (state_reg == ST_WAIT_NB);
    assign busy          = (state_reg != ST_IDLE);
    assign cycle_done    = (state_reg == ST_DONE);

    assign bus.buffer_read_row    = scanning ? iter_row : '0;
    assign bus.buffer_read_column = scanning ? iter_col : '0;
    assign bus.buffer_bank_read   = scanning ? BW'(iter_col % RW'(BANK_COUNT)) : '0;

    // Fan-out: only the port of the in-flight direction can fire, and only for
    // nonzero data; every other port is held at zero.
    logic                               data_nonzero;
    logic [NUM_NEIGHBORS-1:0]           we;
    logic [NUM_NEIGHBORS-1:0][7:0]      value_out;
    logic [NUM_NEIGHBORS-1:0][RW-1:0]   row_out, col_out;

    assign data_nonzero = |bus.buffer_data_read;

    for (genvar gi = 0; gi < NUM_NEIGHBORS; gi++) begin : g_port
        assign we[gi]        = pipe_valid_reg && (pipe_d_reg == 3'(gi)) && data_nonzero;
        assign value_out[gi] = we[gi] ? bus.buffer_data_read : 8'd0;
        assign row_out[gi]   = we[gi] ? pipe_row_reg : '0;
        assign col_out[gi]   = we[gi] ? pipe_col_reg : '0;
    end

    assign bus.neighbor_output_write_enable = we;
    assign bus.neighbor_output_value        = value_out;
    assign bus.neighbor_output_row          = row_out;
    assign bus.neighbor_output_column       = col_out;

endmodule

// File: tb/tb_halo_exchange_scheduler.sv
module tb_halo_exchange_scheduler;

    localparam int L = 8;

    typedef struct packed {
        logic [2:0] d;
        logic [2:0] row;
        logic [2:0] col;
        logic [7:0] val;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] kernel_size;
    logic       channel_group_done;
    logic       local_inputs_pending;
    logic       exchange_done, busy, cycle_done;

    halo_exchange_scheduler_if #(.TILE_SIZE(L), .BANK_COUNT(4)) bus ();

    halo_exchange_scheduler #(.TILE_SIZE(L), .BANK_COUNT(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .kernel_size          (kernel_size),
        .channel_group_done   (channel_group_done),
        .local_inputs_pending (local_inputs_pending),
        .bus                  (bus),
        .exchange_done        (exchange_done),
        .busy                 (busy),
        .cycle_done           (cycle_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output buffer model: data one cycle after the address.
    logic [7:0] tb_mem [L][L];
    always @(posedge clk) bus.buffer_data_read <= tb_mem[bus.buffer_read_row][bus.buffer_read_column];

    // Monitor: records writes and protocol anomalies; tasks judge them.
    bit   mon_en = 0;
    wr_t  obs_q[$];
    int   obs_cyc[$];
    wr_t  exp_q[$];
    int   idle_port_err, multi_we_err, bank_err, ed_first, cd_count, cd_cyc;

    always @(negedge clk) begin
        int  nwe;
        wr_t w;
        if (mon_en) begin
            nwe = 0;
            for (int d = 0; d < 8; d++) begin
                if (bus.neighbor_output_write_enable[d]) begin
                    nwe++;
                    w.d   = 3'(d);
                    w.row = bus.neighbor_output_row[d];
                    w.col = bus.neighbor_output_column[d];
                    w.val = bus.neighbor_output_value[d];
                    obs_q.push_back(w);
                    obs_cyc.push_back(cyc - t0);
                end else if (bus.neighbor_output_value[d] != 0 || bus.neighbor_output_row[d] != 0
                             || bus.neighbor_output_column[d] != 0) begin
                    idle_port_err++;
                end
            end
            if (nwe > 1) multi_we_err++;
            if (exchange_done && ed_first < 0) ed_first = cyc - t0;
            if (cycle_done) begin
                cd_count++;
                cd_cyc = cyc - t0;
            end
            if (32'(bus.buffer_bank_read) != 32'(bus.buffer_read_column) % 4) bank_err++;
        end
    end

    task automatic clear_mon();
        obs_q.delete();
        obs_cyc.delete();
        idle_port_err = 0;
        multi_we_err  = 0;
        bank_err      = 0;
        ed_first      = -1;
        cd_count      = 0;
        cd_cyc        = -1;
    endtask

    task automatic fill_mem(input int zero_pct);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < L; c++)
                tb_mem[r][c] = (int'($urandom_range(0, 99)) < zero_pct) ? 8'd0 : 8'($urandom_range(1, 255));
    endtask

    // Reference: every element of each direction's region, d ascending then
    // row-major, keeping only nonzero values.
    task automatic build_exp(input int h);
        int r0, r1, c0, c1;
        wr_t w;
        exp_q.delete();
        for (int d = 0; d < 8; d++) begin
            r0 = (d == 3 || d == 4 || d == 5) ? L - h : 0;
            r1 = (d == 0 || d == 1 || d == 7) ? h : L;
            c0 = (d == 1 || d == 2 || d == 3) ? L - h : 0;
            c1 = (d == 5 || d == 6 || d == 7) ? h : L;
            for (int r = r0; r < r1; r++)
                for (int c = c0; c < c1; c++)
                    if (tb_mem[r][c] != 0) begin
                        w.d = 3'(d); w.row = 3'(r); w.col = 3'(c); w.val = tb_mem[r][c];
                        exp_q.push_back(w);
                    end
        end
    endtask

    // Runs one exchange; rel cycle 0 is the start-pulse cycle.
    task automatic run_exch(input int ks, input int ncyc, input int drop_dir, input int drop_from,
                            input int drop_len, input int nb_at, input int pend_until,
                            input int restart_at, input bit rand_cts);
        clear_mon();
        @(negedge clk);
        t0 = cyc;
        mon_en = 1;
        for (int rel = 0; rel < ncyc; rel++) begin
            if (rel != 0) @(negedge clk);
            channel_group_done     = (rel == 0 || rel == restart_at);
            kernel_size            = (rel == 0) ? 3'(ks) : (3'(ks) ^ 3'd2);
            local_inputs_pending   = (rel < pend_until);
            bus.neighbor_exchange_done = (rel >= nb_at) ? 8'hFF : 8'h00;
            for (int d = 0; d < 8; d++)
                bus.neighbor_cts[d] = rand_cts ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (drop_dir >= 0 && rel >= drop_from && rel < drop_from + drop_len)
                bus.neighbor_cts[drop_dir] = 1'b0;
        end
        @(negedge clk);
        mon_en = 0;
        channel_group_done = 0;
        bus.neighbor_exchange_done = 8'h00;
        bus.neighbor_cts = 8'hFF;
        $display("exchange ks=%0d writes=%0d exchange_done@%0d cycle_done@%0d x%0d",
                 ks, obs_q.size(), ed_first, cd_cyc, cd_count);
    endtask

    task automatic test_reset();
        reset = 1;
        kernel_size = 3'd3;
        channel_group_done = 0;
        local_inputs_pending = 0;
        bus.neighbor_cts = 8'hFF;
        bus.neighbor_exchange_done = 8'h00;
        for (int r = 0; r < L; r++) for (int c = 0; c < L; c++) tb_mem[r][c] = 8'd1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.neighbor_output_write_enable !== 8'h00) begin
            n_fail++; $display("FAIL reset_we: got %h need 00", bus.neighbor_output_write_enable);
        end
        n_checks++;
        if ({exchange_done, busy, cycle_done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got %b need 000", {exchange_done, busy, cycle_done});
        end
        n_checks++;
        if (bus.neighbor_output_value !== '0 || bus.neighbor_output_row !== '0 || bus.neighbor_output_column !== '0) begin
            n_fail++; $display("FAIL reset_ports: got nonzero value/row/column, need 0");
        end
        reset = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy %b need 0", busy); end
    endtask

    // Cases 1 and 2, plus a start pulse and kernel change while busy.
    task automatic test_full_exchange();
        fill_mem(0);
        build_exp(1);
        run_exch(3, 56, -1, 0, 0, 50, 0, 20, 0);
        n_checks++;
        if (obs_q.size() != 36) begin n_fail++; $display("FAIL full_count: got %0d need 36", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_write[%0d]: got %h need %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_cyc.size() != 36 || obs_cyc[0] != 2 || obs_cyc[35] != 37) begin
            n_fail++; $display("FAIL full_write_window: got first %0d last %0d need 2..37",
                               obs_cyc.size() ? obs_cyc[0] : -1, obs_cyc.size() ? obs_cyc[$] : -1);
        end
        n_checks++;
        if (ed_first != 38) begin n_fail++; $display("FAIL full_exchange_done: got cycle %0d need 38", ed_first); end
        n_checks++;
        if (cd_count != 1 || cd_cyc != 51) begin
            n_fail++; $display("FAIL full_cycle_done: got %0d pulses at %0d need 1 at 51", cd_count, cd_cyc);
        end
        n_checks++;
        if (multi_we_err != 0 || idle_port_err != 0 || bank_err != 0) begin
            n_fail++; $display("FAIL full_port_rules: got multi=%0d idle=%0d bank=%0d need 0",
                               multi_we_err, idle_port_err, bank_err);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL full_idle_after: busy %b need 0", busy); end
    endtask

    task automatic test_zero_halo();
        run_exch(1, 16, -1, 0, 0, 5, 9, -1, 0);
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL zero_halo_writes: got %0d need 0", obs_q.size()); end
        n_checks++;
        if (ed_first != 1) begin n_fail++; $display("FAIL zero_halo_exchange_done: got %0d need 1", ed_first); end
        n_checks++;
        if (cd_count != 1 || cd_cyc != 10) begin
            n_fail++; $display("FAIL zero_halo_cycle_done: got %0d at %0d need 1 at 10", cd_count, cd_cyc);
        end
    endtask

    task automatic test_cts_stall();
        int e_a, e_b;
        fill_mem(0);
        build_exp(1);
        run_exch(3, 50, 2, 12, 5, 46, 0, -1, 0);
        e_a = 0; e_b = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].d == 3'd2 && obs_cyc[i] >= 12 && obs_cyc[i] <= 16) e_a++;
            if (obs_q[i].d == 3'd2 && obs_cyc[i] >= 13 && obs_cyc[i] <= 17) e_b++;
        end
        n_checks++;
        if (e_a != 1) begin n_fail++; $display("FAIL stall_one_more: got %0d E writes need 1", e_a); end
        n_checks++;
        if (e_b != 0) begin n_fail++; $display("FAIL stall_quiet: got %0d E writes need 0", e_b); end
        n_checks++;
        if (obs_q.size() != 36) begin n_fail++; $display("FAIL stall_count: got %0d need 36", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stall_write[%0d]: got %h need %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ed_first != 43 || cd_cyc != 47) begin
            n_fail++; $display("FAIL stall_timing: got done %0d/%0d need 43/47", ed_first, cd_cyc);
        end
    endtask

    task automatic test_sparse_zero();
        fill_mem(0);
        tb_mem[0][3] = 8'd0;
        build_exp(1);
        run_exch(3, 44, -1, 0, 0, 40, 0, -1, 0);
        n_checks++;
        if (obs_q.size() != 35) begin n_fail++; $display("FAIL sparse_count: got %0d need 35", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL sparse_write[%0d]: got %h need %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ed_first != 38) begin n_fail++; $display("FAIL sparse_exchange_done: got %0d need 38", ed_first); end
    endtask

    task automatic test_reset_mid();
        fill_mem(0);
        build_exp(1);
        run_exch(3, 10, -1, 0, 0, 1000, 0, -1, 0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b need 1", busy); end
        reset = 1;
        @(negedge clk);
        n_checks++;
        if (bus.neighbor_output_write_enable !== 8'h00 || bus.neighbor_output_value !== '0
            || bus.neighbor_output_row !== '0 || bus.neighbor_output_column !== '0) begin
            n_fail++; $display("FAIL midreset_ports: got we=%h need all ports 0", bus.neighbor_output_write_enable);
        end
        n_checks++;
        if ({exchange_done, busy, cycle_done} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_status: got %b need 000", {exchange_done, busy, cycle_done});
        end
        n_checks++;
        if (bus.buffer_read_row !== '0 || bus.buffer_read_column !== '0 || bus.buffer_bank_read !== '0) begin
            n_fail++; $display("FAIL midreset_addr: got r%0d c%0d b%0d need 0", bus.buffer_read_row,
                               bus.buffer_read_column, bus.buffer_bank_read);
        end
        reset = 0;
        run_exch(3, 44, -1, 0, 0, 40, 0, -1, 0);
        n_checks++;
        if (obs_q.size() != 36 || ed_first != 38 || cd_cyc != 41) begin
            n_fail++; $display("FAIL midreset_rerun: got %0d writes done %0d/%0d need 36 38/41",
                               obs_q.size(), ed_first, cd_cyc);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midreset_write[%0d]: got %h need %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_halo2();
        fill_mem(0);
        build_exp(2);
        run_exch(5, 90, -1, 0, 0, 85, 0, -1, 0);
        n_checks++;
        if (obs_q.size() != 80) begin n_fail++; $display("FAIL halo2_count: got %0d need 80", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL halo2_write[%0d]: got %h need %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (obs_q.size() == 0 || obs_q[$].d != 3'd7 || obs_q[$].row != 3'd1 || obs_q[$].col != 3'd1) begin
            n_fail++; $display("FAIL halo2_last: got %h need NW (1,1)", obs_q.size() ? obs_q[$] : wr_t'(0));
        end
        n_checks++;
        if (ed_first != 82 || cd_cyc != 86) begin
            n_fail++; $display("FAIL halo2_timing: got %0d/%0d need 82/86", ed_first, cd_cyc);
        end
    endtask

    task automatic test_random();
        int ks;
        for (int it = 0; it < 6; it++) begin
            ks = 1 + 2 * int'($urandom_range(0, 3));
            fill_mem(20);
            build_exp(ks >> 1);
            run_exch(ks, 240, -1, 0, 0, 230, 0, -1, 1);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d need %0d", it, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_write[%0d]: got %h need %h", it, i, obs_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (cd_count != 1 || cd_cyc != 231 || ed_first < 1 || ed_first >= 230) begin
                n_fail++; $display("FAIL rand%0d_done: got cd %0d@%0d ed@%0d need 1@231", it, cd_count, cd_cyc, ed_first);
            end
            n_checks++;
            if (multi_we_err != 0 || idle_port_err != 0 || bank_err != 0) begin
                n_fail++; $display("FAIL rand%0d_port_rules: got multi=%0d idle=%0d bank=%0d need 0",
                                   it, multi_we_err, idle_port_err, bank_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_exchange();
        test_zero_halo();
        test_cts_stall();
        test_sparse_zero();
        test_reset_mid();
        test_halo2();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, need completion");
        $fatal(1, "watchdog");
    end

endmodule
